request_dispatcher: RTL and testbench
=====================================

// Module: request_dispatcher
// PURPOSE
//  Producer side of the movement panel interface. Latches raw car and hall button presses as pending
//  requests and tracks the car's floor from the engine/doors commands that movement drives. Presents
//  exactly one request at a time on interior_panel/exterior_panel and holds it until the request is served.
// PARAMETERS
//  FLOORS        3  number of floors; width of every one-hot floor vector
//  TRAVEL_TICKS  4  My_Clock rising edges of continuous motion per floor step (>=1)
// PORTS
//  CLK             in   1       system clock; all logic on posedge
//  RST             in   1       synchronous, active-high reset
//  My_Clock        in   1       slow time base; only its rising edge (sampled on CLK) counts
//  car_btn         in   FLOORS  raw interior buttons, level, bit i = floor i
//  hall_btn        in   FLOORS  raw exterior buttons, level, bit i = floor i
//  engine          in   2       from movement: 00 stop, 01 up, 10 down, 11 treated as stop
//  doors           in   FLOORS  from movement: bit i = door at floor i open
//  interior_panel  out  FLOORS  presented car request, one-hot or zero
//  exterior_panel  out  FLOORS  presented hall request, one-hot or zero
//  car_pending     out  FLOORS  latched car requests (lamp drive)
//  hall_pending    out  FLOORS  latched hall requests (lamp drive)
//  cur_floor       out  FLOORS  tracked car position, one-hot
//  busy            out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: panels, pending vectors and travel counter = 0; cur_floor = 1 (floor 0); busy = 0; FSM = IDLE.
//  Capture: a button's 0->1 edge, registered on CLK, sets its pending bit 1 cycle later. A held level
//   never re-sets a cleared bit. Button edge and clear on the same bit in the same cycle: clear wins.
//  Clear: pending bit i (both classes) is cleared when doors[i] && cur_floor[i].
//  Floor tracking: the travel counter increments on each My_Clock rising edge while engine is 01/10.
//   At TRAVEL_TICKS it resets and cur_floor shifts up or down, saturating at the end floors.
//   The counter zeroes on engine stop or a direction change.
//  FSM:
//   IDLE:    if any pending, select a target and go to PRESENT next cycle; otherwise stay.
//            Select: car class beats hall class; within a class, the nearest floor to cur_floor;
//            a tie goes to the lower index.
//   PRESENT: drive the one-hot target on its own panel only; the other panel stays 0. Hold the target
//            stable, with no re-arbitration, until its pending bit clears; then go to DRAIN.
//   DRAIN:   panels = 0 for exactly 1 cycle, then go to IDLE. This guarantees a 0 gap between requests.
//  Target already at cur_floor with doors open on entry: cleared in the same cycle, PRESENT lasts 1 cycle.
//  Panel latency from button edge: 3 cycles minimum (capture, IDLE select, PRESENT).
//  RST mid-PRESENT: panels drop to 0 on the next edge and all pending requests are lost.
// CONFIGURATION
//  REQ_CANCEL_EN defined: a new edge on an already-pending car_btn bit that is not currently presented
//   clears that bit (passenger cancel). Hall requests are never cancelable.
//  REQ_CANCEL_EN undefined: repeated edges on a pending bit are ignored.
// STRUCTURE
//  Package elevator_pkg holds:
//   - ENG_STOP/ENG_UP/ENG_DOWN encodings
//   - the FSM state encodings IDLE/PRESENT/DRAIN
//   - the FLOORS default
//  Sub-module floor_tracker (My_Clock edge detect, travel counter, cur_floor shifter) is instantiated once.
//  The top level holds capture, clear, arbitration and the FSM.
// TESTING
//  1 Reset, car_btn=010 for 2 cycles
//    -> car_pending=010 next cycle; interior_panel=010 3 cycles after the edge; exterior_panel=000.
//  2 From scenario 1, engine=01 for 4 My_Clock edges
//    -> cur_floor 001->010. Then doors=010 -> pending cleared, panel 0 for 1 cycle, busy=0.
//  3 car_btn=100 and hall_btn=001 in the same cycle with cur_floor=001
//    -> interior_panel=100 served first; exterior_panel=001 presented only after DRAIN.
//  4 cur_floor=010, hall_btn=101
//    -> tie broken to the lower index: exterior_panel=001.
//  5 engine=10 at floor 0 for 8 My_Clock edges
//    -> cur_floor stays 001. RST during PRESENT -> all outputs return to reset values next edge.
//  6 REQ_CANCEL_EN: car_btn 001 pressed twice while 100 is presented -> car_pending[0]=0.
//    Without the macro -> car_pending[0] stays 1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator request dispatcher.
// Engine command codes, dispatcher FSM states and default floor count.
package elevator_pkg;

    localparam int DEFAULT_FLOORS = 3;

    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/floor_tracker.sv
// Tracks the car position from engine commands and the slow My_Clock base.
// Ports: clk_i, rst_i (sync, high), my_clock_i, engine_i[1:0] -> cur_floor_o (one-hot).
module floor_tracker
    import elevator_pkg::*;
#(
    parameter int FLOORS       = DEFAULT_FLOORS,
    parameter int TRAVEL_TICKS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              my_clock_i,
    input  logic [1:0]        engine_i,
    output logic [FLOORS-1:0] cur_floor_o
);

    localparam int CW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TRAVEL_TICKS - 1);

    logic              mc_q;
    logic [1:0]        eng_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FLOORS-1:0] floor_q, floor_d;
    logic              mc_rise, moving, was_moving, flip;

    always_comb begin
        mc_rise    = my_clock_i & ~mc_q;
        moving     = (engine_i == ENG_UP) || (engine_i == ENG_DOWN);
        was_moving = (eng_q == ENG_UP) || (eng_q == ENG_DOWN);
        // Only an up<->down reversal restarts travel; leaving stop starts at 0 anyway.
        flip       = moving && was_moving && (engine_i != eng_q);
        cnt_d      = cnt_q;
        floor_d    = floor_q;
        if (!moving || flip) begin
            cnt_d = '0;
        end else if (mc_rise) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                if (engine_i == ENG_UP) begin
                    if (!floor_q[FLOORS-1]) floor_d = floor_q << 1;
                end else begin
                    if (!floor_q[0]) floor_d = floor_q >> 1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mc_q    <= 1'b0;
            eng_q   <= ENG_STOP;
            cnt_q   <= '0;
            floor_q <= FLOORS'(1);
        end else begin
            mc_q    <= my_clock_i;
            eng_q   <= engine_i;
            cnt_q   <= cnt_d;
            floor_q <= floor_d;
        end
    end

    assign cur_floor_o = floor_q;

endmodule

// File: rtl/request_dispatcher.sv
// Latches car/hall presses and presents one request at a time to movement.
// Ports: CLK, RST (sync, high), My_Clock, car_btn, hall_btn, engine, doors ->
//   interior_panel, exterior_panel, car_pending, hall_pending, cur_floor, busy.
// Option: REQ_CANCEL_EN enables passenger cancel of a pending, unpresented car request.
module request_dispatcher
    import elevator_pkg::*;
#(
    parameter int FLOORS       = DEFAULT_FLOORS,
    parameter int TRAVEL_TICKS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              My_Clock,
    input  logic [FLOORS-1:0] car_btn,
    input  logic [FLOORS-1:0] hall_btn,
    input  logic [1:0]        engine,
    input  logic [FLOORS-1:0] doors,
    output logic [FLOORS-1:0] interior_panel,
    output logic [FLOORS-1:0] exterior_panel,
    output logic [FLOORS-1:0] car_pending,
    output logic [FLOORS-1:0] hall_pending,
    output logic [FLOORS-1:0] cur_floor,
    output logic              busy
);

    logic [FLOORS-1:0] car_s1_q, car_s2_q, hall_s1_q, hall_s2_q;
    logic [FLOORS-1:0] car_pend_q, car_pend_d, hall_pend_q, hall_pend_d;
    logic [FLOORS-1:0] tgt_q, tgt_d;
    logic              tgt_car_q, tgt_car_d;
    state_e            state_q, state_d;

    logic [FLOORS-1:0] car_edge, hall_edge, clear, car_cancel, sel;
    int                cur_idx;

    floor_tracker #(
        .FLOORS      (FLOORS),
        .TRAVEL_TICKS(TRAVEL_TICKS)
    ) u_tracker (
        .clk_i      (CLK),
        .rst_i      (RST),
        .my_clock_i (My_Clock),
        .engine_i   (engine),
        .cur_floor_o(cur_floor)
    );

    // Nearest requested floor; ascending scan with strict compare favours lower index.
    function automatic logic [FLOORS-1:0] nearest(
        input logic [FLOORS-1:0] req,
        input int                cur
    );
        logic [FLOORS-1:0] pick;
        int                best, d;
        pick = '0;
        best = FLOORS;
        for (int i = 0; i < FLOORS; i++) begin
            d = (i > cur) ? (i - cur) : (cur - i);
            if (req[i] && d < best) begin
                best    = d;
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        cur_idx = 0;
        for (int i = 0; i < FLOORS; i++) begin
            if (cur_floor[i]) cur_idx = i;
        end
    end

    always_comb begin
        car_edge  = car_s1_q & ~car_s2_q;
        hall_edge = hall_s1_q & ~hall_s2_q;
        clear     = doors & cur_floor;
`ifdef REQ_CANCEL_EN
        car_cancel = car_edge & car_pend_q &
                     ~((state_q == PRESENT && tgt_car_q) ? tgt_q : '0);
`else
        car_cancel = '0;
`endif
        // Clear is applied last so it beats a same-cycle edge.
        car_pend_d  = (car_pend_q | car_edge) & ~car_cancel & ~clear;
        hall_pend_d = (hall_pend_q | hall_edge) & ~clear;
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        tgt_car_d = tgt_car_q;
        sel       = tgt_car_q ? car_pend_d : hall_pend_d;
        unique case (state_q)
            IDLE: begin
                if (|car_pend_q) begin
                    tgt_d     = nearest(car_pend_q, cur_idx);
                    tgt_car_d = 1'b1;
                    state_d   = PRESENT;
                end else if (|hall_pend_q) begin
                    tgt_d     = nearest(hall_pend_q, cur_idx);
                    tgt_car_d = 1'b0;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                // Looking at next-state pending lets an instant clear end PRESENT in 1 cycle.
                if (!(|(sel & tgt_q))) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            car_s1_q    <= '0;
            car_s2_q    <= '0;
            hall_s1_q   <= '0;
            hall_s2_q   <= '0;
            car_pend_q  <= '0;
            hall_pend_q <= '0;
            tgt_q       <= '0;
            tgt_car_q   <= 1'b0;
            state_q     <= IDLE;
        end else begin
            car_s1_q    <= car_btn;
            car_s2_q    <= car_s1_q;
            hall_s1_q   <= hall_btn;
            hall_s2_q   <= hall_s1_q;
            car_pend_q  <= car_pend_d;
            hall_pend_q <= hall_pend_d;
            tgt_q       <= tgt_d;
            tgt_car_q   <= tgt_car_d;
            state_q     <= state_d;
        end
    end

    assign interior_panel = (state_q == PRESENT && tgt_car_q)  ? tgt_q : '0;
    assign exterior_panel = (state_q == PRESENT && !tgt_car_q) ? tgt_q : '0;
    assign car_pending    = car_pend_q;
    assign hall_pending   = hall_pend_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_request_dispatcher.sv
// Self-checking bench for request_dispatcher: behavioural model plus directed scenarios.
// Outputs are compared against the model on every falling CLK edge.
module tb_request_dispatcher;

    localparam int F  = 3;
    localparam int TT = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         My_Clock = 1'b0;
    logic [F-1:0] car_btn = '0, hall_btn = '0, doors = '0;
    logic [1:0]   engine = 2'b00;
    logic [F-1:0] interior_panel, exterior_panel, car_pending, hall_pending, cur_floor;
    logic         busy;

    int checks = 0;
    int failures = 0;

    request_dispatcher #(.FLOORS(F), .TRAVEL_TICKS(TT)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .My_Clock      (My_Clock),
        .car_btn       (car_btn),
        .hall_btn      (hall_btn),
        .engine        (engine),
        .doors         (doors),
        .interior_panel(interior_panel),
        .exterior_panel(exterior_panel),
        .car_pending   (car_pending),
        .hall_pending  (hall_pending),
        .cur_floor     (cur_floor),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [F-1:0] m_cp, m_hp, m_ch1, m_ch2, m_hh1, m_hh2;
    int           m_pos, m_ticks, m_phase, m_tgt;
    bit           m_tgtc, m_mcp, m_started = 0;
    logic [1:0]   m_last;

    function automatic int nearest(logic [F-1:0] v, int pos);
        for (int d = 0; d < F; d++) begin
            if (pos - d >= 0 && v[pos-d]) return pos - d;
            if (pos + d < F && v[pos+d]) return pos + d;
        end
        return 0;
    endfunction

    always @(posedge CLK) begin
        logic [F-1:0] ncp, nhp;
        int  nphase, ntgt, npos, nticks;
        bit  ntgtc, ce, he, clr, canc, mv, lmv;
        m_started <= 1;
        if (RST) begin
            m_cp <= '0; m_hp <= '0;
            m_ch1 <= '0; m_ch2 <= '0; m_hh1 <= '0; m_hh2 <= '0;
            m_pos <= 0; m_ticks <= 0; m_phase <= 0; m_tgt <= 0;
            m_tgtc <= 0; m_mcp <= 0; m_last <= 2'b00;
        end else begin
            for (int i = 0; i < F; i++) begin
                ce   = m_ch1[i] && !m_ch2[i];
                he   = m_hh1[i] && !m_hh2[i];
                clr  = doors[i] && (m_pos == i);
                canc = 0;
`ifdef REQ_CANCEL_EN
                canc = ce && m_cp[i] && !(m_phase == 1 && m_tgtc && m_tgt == i);
`endif
                ncp[i] = (clr || canc) ? 1'b0 : (m_cp[i] | ce);
                nhp[i] = clr ? 1'b0 : (m_hp[i] | he);
            end
            nphase = m_phase; ntgt = m_tgt; ntgtc = m_tgtc;
            case (m_phase)
                0: if (m_cp != 0) begin
                       ntgt = nearest(m_cp, m_pos); ntgtc = 1; nphase = 1;
                   end else if (m_hp != 0) begin
                       ntgt = nearest(m_hp, m_pos); ntgtc = 0; nphase = 1;
                   end
                1: if (m_tgtc ? !ncp[m_tgt] : !nhp[m_tgt]) nphase = 2;
                default: nphase = 0;
            endcase
            npos = m_pos; nticks = m_ticks;
            mv  = (engine == 2'b01) || (engine == 2'b10);
            lmv = (m_last == 2'b01) || (m_last == 2'b10);
            if (!mv) nticks = 0;
            else if (lmv && engine != m_last) nticks = 0;
            else if (My_Clock && !m_mcp) begin
                nticks = m_ticks + 1;
                if (nticks == TT) begin
                    nticks = 0;
                    if (engine == 2'b01) npos = (m_pos < F - 1) ? m_pos + 1 : m_pos;
                    else                 npos = (m_pos > 0) ? m_pos - 1 : m_pos;
                end
            end
            m_cp <= ncp; m_hp <= nhp;
            m_ch2 <= m_ch1; m_ch1 <= car_btn;
            m_hh2 <= m_hh1; m_hh1 <= hall_btn;
            m_phase <= nphase; m_tgt <= ntgt; m_tgtc <= ntgtc;
            m_pos <= npos; m_ticks <= nticks;
            m_mcp <= My_Clock; m_last <= engine;
        end
    end

    always @(negedge CLK) begin
        logic [F-1:0] ei, ee;
        if (m_started) begin
            ei = (m_phase == 1 && m_tgtc)  ? F'(1) << m_tgt : '0;
            ee = (m_phase == 1 && !m_tgtc) ? F'(1) << m_tgt : '0;
            chk("m_interior", 32'(interior_panel), 32'(ei));
            chk("m_exterior", 32'(exterior_panel), 32'(ee));
            chk("m_car_pend", 32'(car_pending), 32'(m_cp));
            chk("m_hall_pend", 32'(hall_pending), 32'(m_hp));
            chk("m_cur_floor", 32'(cur_floor), 32'(F'(1) << m_pos));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            My_Clock = 1'b1; cyc(1);
            My_Clock = 1'b0; cyc(1);
        end
    endtask

    initial begin
        cyc(2);
        chk("rst_cur", 32'(cur_floor), 32'b001);
        chk("rst_busy", 32'(busy), 32'b0);
        chk("rst_int", 32'(interior_panel), 32'b000);
        RST = 1'b0;

        // 1: car request at floor 1
        car_btn = 3'b010;
        cyc(2);
        car_btn = 3'b000;
        chk("s1_pend", 32'(car_pending), 32'b010);
        chk("s1_int_early", 32'(interior_panel), 32'b000);
        cyc(1);
        chk("s1_int", 32'(interior_panel), 32'b010);
        chk("s1_ext", 32'(exterior_panel), 32'b000);

        // 2: travel up one floor, serve
        engine = 2'b01;
        tick(4);
        chk("s2_cur", 32'(cur_floor), 32'b010);
        engine = 2'b00; doors = 3'b010;
        cyc(1);
        doors = 3'b000;
        chk("s2_pend", 32'(car_pending), 32'b000);
        chk("s2_drain", 32'(interior_panel), 32'b000);
        chk("s2_busy_d", 32'(busy), 32'b1);
        cyc(1);
        chk("s2_busy", 32'(busy), 32'b0);

        // 3: car beats hall
        engine = 2'b10;
        tick(4);
        engine = 2'b00;
        chk("s3_cur", 32'(cur_floor), 32'b001);
        car_btn = 3'b100; hall_btn = 3'b001;
        cyc(1);
        car_btn = 3'b000; hall_btn = 3'b000;
        cyc(2);
        chk("s3_int", 32'(interior_panel), 32'b100);
        chk("s3_ext0", 32'(exterior_panel), 32'b000);
        engine = 2'b01;
        tick(8);
        engine = 2'b00; doors = 3'b100;
        cyc(1);
        doors = 3'b000;
        chk("s3_drain", 32'(interior_panel | exterior_panel), 32'b000);
        cyc(1);
        chk("s3_idle", 32'(exterior_panel), 32'b000);
        cyc(1);
        chk("s3_ext", 32'(exterior_panel), 32'b001);
        chk("s3_int0", 32'(interior_panel), 32'b000);
        engine = 2'b10;
        tick(8);
        engine = 2'b00; doors = 3'b001;
        cyc(1);
        doors = 3'b000;
        cyc(2);

        // 4: tie at floor 1 goes to floor 0
        engine = 2'b01;
        tick(4);
        engine = 2'b00;
        hall_btn = 3'b101;
        cyc(1);
        hall_btn = 3'b000;
        cyc(2);
        chk("s4_ext", 32'(exterior_panel), 32'b001);
        chk("s4_hpend", 32'(hall_pending), 32'b101);

        // 5: reset mid-PRESENT, then down saturation at floor 0
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("s5_ext", 32'(exterior_panel), 32'b000);
        chk("s5_hpend", 32'(hall_pending), 32'b000);
        chk("s5_cur", 32'(cur_floor), 32'b001);
        chk("s5_busy", 32'(busy), 32'b0);
        engine = 2'b10;
        tick(8);
        engine = 2'b00;
        chk("s5_sat_lo", 32'(cur_floor), 32'b001);

        // 6: second press on a pending, unpresented car request
        car_btn = 3'b100;
        cyc(1);
        car_btn = 3'b000;
        cyc(2);
        chk("s6_int", 32'(interior_panel), 32'b100);
        car_btn = 3'b001; cyc(1);
        car_btn = 3'b000; cyc(1);
        chk("s6_pend1", 32'(car_pending), 32'b101);
        car_btn = 3'b001; cyc(1);
        car_btn = 3'b000; cyc(3);
`ifdef REQ_CANCEL_EN
        chk("s6_cancel", 32'(car_pending), 32'b100);
`else
        chk("s6_keep", 32'(car_pending), 32'b101);
`endif
        chk("s6_int_hold", 32'(interior_panel), 32'b100);

        // up saturation at the top floor
        engine = 2'b01;
        tick(12);
        engine = 2'b00;
        chk("sat_hi", 32'(cur_floor), 32'b100);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
